// File: rtl/pwm_pkg.sv
// Shared types, defaults and helpers for the PWM compare stage.
package pwm_pkg;

  typedef enum logic [1:0] {
    OFF = 2'd0,
    ARM = 2'd1,
    RUN = 2'd2
  } state_e;

  localparam int unsigned PWM_WIDTH_DEF = 8;
  localparam int unsigned PERIOD_CNT_W  = 8;

  // True when count holds the all-ones value for a counter of the given width.
  function automatic logic is_wrap(input logic [31:0] count, input int unsigned width);
    return count == ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/pwm_compare_stage_if.sv
// Duty-update valid/ready channel into the PWM compare stage.
interface pwm_compare_stage_if
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_WIDTH_DEF
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_duty;

  modport master (output load_valid, output load_duty, input  load_ready);
  modport slave  (input  load_valid, input  load_duty, output load_ready);
endinterface

// File: rtl/pwm_deadband.sv
// Dead-band generator producing non-overlapping pwm/pwm_n from the raw compare.
// Present only when PWM_COMPLEMENT_EN is defined.
`ifdef PWM_COMPLEMENT_EN
module pwm_deadband #(
  parameter int unsigned DEADTIME = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic raw,
  output logic pwm,
  output logic pwm_n
);
  localparam int unsigned RUN_W = 5;
  localparam logic [RUN_W-1:0] HOLD = RUN_W'(DEADTIME + 1);

  logic             raw_q;
  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_c;

  // Cycles raw has held its present value, including this one; saturates at HOLD.
  always_comb begin
    run_c = run_q;
    if (raw != raw_q) begin
      run_c = RUN_W'(1);
    end else if (run_q < HOLD) begin
      run_c = run_q + RUN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      raw_q <= 1'b0;
      run_q <= '0;
      pwm   <= 1'b0;
      pwm_n <= 1'b0;
    end else begin
      raw_q <= raw;
      run_q <= run_c;
      pwm   <= active &&  raw && (run_c >= HOLD);
      pwm_n <= active && !raw && (run_c >= HOLD);
    end
  end

endmodule
`endif

// File: rtl/pwm_compare_stage.sv
// PWM compare stage: double-buffered duty, run FSM, compare, period tick and count.
// Build option PWM_COMPLEMENT_EN adds pwm_n with a DEADTIME dead band.
module pwm_compare_stage
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH    = PWM_WIDTH_DEF,
  parameter int unsigned DEADTIME = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [WIDTH-1:0]        count_in,
  pwm_compare_stage_if.slave      load_if,
  output logic                    pwm,
`ifdef PWM_COMPLEMENT_EN
  output logic                    pwm_n,
`endif
  output logic                    period_tick,
  output logic [PERIOD_CNT_W-1:0] period_cnt,
  output logic                    busy
);

  if (DEADTIME < 1 || DEADTIME > 15) begin : g_bad_deadtime
    $error("pwm_compare_stage: DEADTIME must be in 1..15");
  end

  state_e                  state_q, state_d;
  logic                    pending_q, pending_d;
  logic [WIDTH-1:0]        duty_pending_q, duty_pending_d;
  logic [WIDTH-1:0]        duty_active_q, duty_active_d;
  logic                    tick_d;
  logic [PERIOD_CNT_W-1:0] cnt_d;
  logic                    wrap_c, accept_c, run_en_c, raw_c;

  assign wrap_c   = is_wrap(32'(count_in), WIDTH);
  assign accept_c = load_if.load_valid && !pending_q;
  // Dropping enable silences the outputs at the very next edge, ahead of the state change.
  assign run_en_c = (state_q == RUN) && enable;
  assign raw_c    = run_en_c && (count_in < duty_active_q);

  assign load_if.load_ready = !pending_q;
  assign busy               = (state_q != OFF);

  // Run FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OFF:     if (enable) state_d = ARM;
      ARM:     if (!enable) state_d = OFF;
               else if (wrap_c) state_d = RUN;
      RUN:     if (!enable) state_d = OFF;
      default: state_d = OFF;
    endcase
  end

  // Duty shadow: accept into pending, promote to active at wrap.
  always_comb begin
    pending_d      = pending_q;
    duty_pending_d = duty_pending_q;
    duty_active_d  = duty_active_q;
    if (accept_c) begin
      duty_pending_d = load_if.load_duty;
      pending_d      = 1'b1;
    end else if (wrap_c && pending_q) begin
      duty_active_d  = duty_pending_q;
      pending_d      = 1'b0;
    end
  end

  // Period tick and count; the count holds zero whenever the FSM is headed to OFF.
  always_comb begin
    tick_d = run_en_c && wrap_c;
    cnt_d  = period_cnt + PERIOD_CNT_W'(tick_d);
    if (state_d == OFF) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= OFF;
      pending_q      <= 1'b0;
      duty_pending_q <= '0;
      duty_active_q  <= '0;
      period_tick    <= 1'b0;
      period_cnt     <= '0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      duty_pending_q <= duty_pending_d;
      duty_active_q  <= duty_active_d;
      period_tick    <= tick_d;
      period_cnt     <= cnt_d;
    end
  end

`ifdef PWM_COMPLEMENT_EN
  pwm_deadband #(
    .DEADTIME (DEADTIME)
  ) u_deadband (
    .clk    (clk),
    .rst_n  (rst_n),
    .active (run_en_c),
    .raw    (raw_c),
    .pwm    (pwm),
    .pwm_n  (pwm_n)
  );
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm <= 1'b0;
    end else begin
      pwm <= raw_c;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_compare_stage.sv
// Self-checking bench for pwm_compare_stage; per-period expectations flow through a queue.
module tb_pwm_compare_stage;
  localparam int unsigned WIDTH = 8;
  localparam int          DT    = 2;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       enable   = 1'b0;
  logic [7:0] count_in = 8'd0;
  logic       pwm, period_tick, busy;
  logic [7:0] period_cnt;
`ifdef PWM_COMPLEMENT_EN
  logic       pwm_n;
`endif

  pwm_compare_stage_if #(.WIDTH(WIDTH)) load_if ();

  pwm_compare_stage #(.WIDTH(WIDTH), .DEADTIME(DT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .count_in    (count_in),
    .load_if     (load_if),
    .pwm         (pwm),
`ifdef PWM_COMPLEMENT_EN
    .pwm_n       (pwm_n),
`endif
    .period_tick (period_tick),
    .period_cnt  (period_cnt),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int exp_pc = 0;

  function automatic int exp_high(input int duty);
`ifdef PWM_COMPLEMENT_EN
    return (duty > DT) ? duty - DT : 0;
`else
    return duty;
`endif
  endfunction

  function automatic int exp_first(input int duty);
`ifdef PWM_COMPLEMENT_EN
    return (duty > DT) ? DT : -1;
`else
    return (duty > 0) ? 0 : -1;
`endif
  endfunction

  // One clock: outputs are stable #1 after the edge, then the counter advances.
  task automatic cyc();
    @(posedge clk);
    #1;
    count_in = count_in + 8'd1;
  endtask

  task automatic advance_to(input logic [7:0] c);
    for (int n = 0; n < 300 && count_in != c; n++) cyc();
  endtask

  task automatic load(input logic [7:0] d);
    int n = 0;
    while (load_if.load_ready !== 1'b1 && n < 600) begin
      cyc();
      n++;
    end
    checks++;
    if (load_if.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_ready_wait: load_ready=%b required 1", load_if.load_ready);
    end
    load_if.load_valid = 1'b1;
    load_if.load_duty  = d;
    cyc();
    load_if.load_valid = 1'b0;
  endtask

  // Observes one full period starting with count_in==0 presented; optional load at index load_at.
  task automatic measure_period(input int load_at, input logic [7:0] load_val,
                                output int high, output int ticks, output int first_hi,
                                output int ready_lo, output int high_n, output int both);
    high = 0; ticks = 0; first_hi = -1; ready_lo = 0; high_n = 0; both = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == load_at) begin
        load_if.load_valid = 1'b1;
        load_if.load_duty  = load_val;
      end
      cyc();
      load_if.load_valid = 1'b0;
      if (pwm === 1'b1) begin
        high++;
        if (first_hi < 0) first_hi = i;
      end
      if (period_tick === 1'b1) ticks++;
      if (load_if.load_ready !== 1'b1) ready_lo++;
`ifdef PWM_COMPLEMENT_EN
      if (pwm_n === 1'b1) high_n++;
      if (pwm === 1'b1 && pwm_n === 1'b1) both++;
`endif
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0;
    load_if.load_valid = 1'b0; load_if.load_duty = 8'd0;
    repeat (3) cyc();
    checks++; if (pwm !== 1'b0) begin errors++; $display("FAIL reset_pwm: got %b want 0", pwm); end
    checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", period_tick); end
    checks++; if (period_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", period_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    cyc();
    checks++; if (load_if.load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", load_if.load_ready); end
  endtask

  task automatic test_basic();
    int arm_hi = 0, arm_tk = 0;
    int high, ticks, first_hi, ready_lo, high_n, both, e;
    load(8'd64);
    advance_to(8'd0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL off_busy: got %b want 0", busy); end
    advance_to(8'd10);
    enable = 1'b1;
    cyc();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arm_busy: got %b want 1", busy); end
    for (int n = 0; n < 300 && count_in != 8'd0; n++) begin
      cyc();
      if (pwm === 1'b1) arm_hi++;
`ifdef PWM_COMPLEMENT_EN
      if (pwm_n === 1'b1) arm_hi++;
`endif
      if (period_tick === 1'b1) arm_tk++;
    end
    checks++; if (arm_hi != 0) begin errors++; $display("FAIL arm_pwm: high cycles %0d want 0", arm_hi); end
    checks++; if (arm_tk != 0) begin errors++; $display("FAIL arm_tick: ticks %0d want 0", arm_tk); end
    exp_pc = 0;
    exp_q.push_back(exp_high(64));
    measure_period(-1, 8'd0, high, ticks, first_hi, ready_lo, high_n, both);
    e = exp_q.pop_front();
    exp_pc++;
    checks++; if (high != e) begin errors++; $display("FAIL basic_high: got %0d want %0d", high, e); end
    checks++; if (first_hi != exp_first(64)) begin errors++; $display("FAIL basic_first: got %0d want %0d", first_hi, exp_first(64)); end
    checks++; if (ticks != 1) begin errors++; $display("FAIL basic_ticks: got %0d want 1", ticks); end
    checks++; if (period_cnt !== 8'(exp_pc)) begin errors++; $display("FAIL basic_cnt: got %0d want %0d", period_cnt, exp_pc); end
  endtask

  task automatic test_mid_load();
    int high, ticks, first_hi, ready_lo, high_n, both, e;
    exp_q.push_back(exp_high(64));
    exp_q.push_back(exp_high(200));
    measure_period(100, 8'd200, high, ticks, first_hi, ready_lo, high_n, both);
    e = exp_q.pop_front(); exp_pc++;
    checks++; if (high != e) begin errors++; $display("FAIL midload_cur_high: got %0d want %0d", high, e); end
    checks++; if (ready_lo != 155) begin errors++; $display("FAIL midload_ready_low: got %0d want 155", ready_lo); end
    measure_period(-1, 8'd0, high, ticks, first_hi, ready_lo, high_n, both);
    e = exp_q.pop_front(); exp_pc++;
    checks++; if (high != e) begin errors++; $display("FAIL midload_next_high: got %0d want %0d", high, e); end
    checks++; if (ready_lo != 0) begin errors++; $display("FAIL midload_ready_after: got %0d want 0", ready_lo); end
    checks++; if (period_cnt !== 8'(exp_pc)) begin errors++; $display("FAIL midload_cnt: got %0d want %0d", period_cnt, exp_pc); end
  endtask

  task automatic test_back_to_back_wrap_load();
    int high, ticks, first_hi, ready_lo, high_n, both, e;
    exp_q.push_back(exp_high(200));
    exp_q.push_back(exp_high(200));
    exp_q.push_back(exp_high(32));
    measure_period(255, 8'd32, high, ticks, first_hi, ready_lo, high_n, both);
    e = exp_q.pop_front(); exp_pc++;
    checks++; if (high != e) begin errors++; $display("FAIL wrapload_a_high: got %0d want %0d", high, e); end
    checks++; if (ready_lo != 1) begin errors++; $display("FAIL wrapload_a_ready: got %0d want 1", ready_lo); end
    measure_period(-1, 8'd0, high, ticks, first_hi, ready_lo, high_n, both);
    e = exp_q.pop_front(); exp_pc++;
    checks++; if (high != e) begin errors++; $display("FAIL wrapload_b_high: got %0d want %0d", high, e); end
    checks++; if (ready_lo != 255) begin errors++; $display("FAIL wrapload_b_ready: got %0d want 255", ready_lo); end
    measure_period(-1, 8'd0, high, ticks, first_hi, ready_lo, high_n, both);
    e = exp_q.pop_front(); exp_pc++;
    checks++; if (high != e) begin errors++; $display("FAIL wrapload_c_high: got %0d want %0d", high, e); end
  endtask

  task automatic test_extremes_and_wrap();
    int high, ticks, first_hi, ready_lo, high_n, both, e;
    int bad = 0;
    exp_q.push_back(exp_high(32));
    exp_q.push_back(exp_high(0));
    exp_q.push_back(exp_high(255));
    measure_period(10, 8'd0, high, ticks, first_hi, ready_lo, high_n, both);
    e = exp_q.pop_front(); exp_pc++;
    checks++; if (high != e) begin errors++; $display("FAIL ext_32_high: got %0d want %0d", high, e); end
    measure_period(10, 8'd255, high, ticks, first_hi, ready_lo, high_n, both);
    e = exp_q.pop_front(); exp_pc++;
    checks++; if (high != e) begin errors++; $display("FAIL ext_0_high: got %0d want %0d", high, e); end
    measure_period(-1, 8'd0, high, ticks, first_hi, ready_lo, high_n, both);
    e = exp_q.pop_front(); exp_pc++;
    checks++; if (high != e) begin errors++; $display("FAIL ext_255_high: got %0d want %0d", high, e); end
    checks++; if (first_hi != exp_first(255)) begin errors++; $display("FAIL ext_255_first: got %0d want %0d", first_hi, exp_first(255)); end
    for (int n = 0; n < 300 && period_cnt != 8'd0; n++) begin
      measure_period(-1, 8'd0, high, ticks, first_hi, ready_lo, high_n, both);
      exp_pc++;
      if (high != exp_high(255) || ticks != 1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL cnt_run_periods: bad periods %0d want 0", bad); end
    checks++; if (exp_pc != 256) begin errors++; $display("FAIL cnt_wrap_len: periods to wrap %0d want 256", exp_pc); end
    checks++; if (period_cnt !== 8'd0) begin errors++; $display("FAIL cnt_wrap_value: got %0d want 0", period_cnt); end
  endtask

  task automatic test_disable_and_reset();
    int high, ticks, first_hi, ready_lo, high_n, both, e;
    advance_to(8'd100);
    checks++; if (pwm !== 1'b1) begin errors++; $display("FAIL dis_pre_pwm: got %b want 1", pwm); end
    enable = 1'b0;
    cyc();
    checks++; if (pwm !== 1'b0) begin errors++; $display("FAIL dis_pwm: got %b want 0", pwm); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dis_busy: got %b want 0", busy); end
    checks++; if (period_cnt !== 8'd0) begin errors++; $display("FAIL dis_cnt: got %0d want 0", period_cnt); end
    checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL dis_tick: got %b want 0", period_tick); end
    enable = 1'b1;
    advance_to(8'd0);
    exp_pc = 0;
    exp_q.push_back(exp_high(255));
    measure_period(-1, 8'd0, high, ticks, first_hi, ready_lo, high_n, both);
    e = exp_q.pop_front(); exp_pc++;
    checks++; if (high != e) begin errors++; $display("FAIL dis_retained_high: got %0d want %0d", high, e); end
    checks++; if (period_cnt !== 8'(exp_pc)) begin errors++; $display("FAIL dis_restart_cnt: got %0d want %0d", period_cnt, exp_pc); end
    advance_to(8'd20);
    load(8'd77);
    checks++; if (load_if.load_ready !== 1'b0) begin errors++; $display("FAIL rst_pending_ready: got %b want 0", load_if.load_ready); end
    advance_to(8'd50);
    rst_n = 1'b0;
    cyc();
    checks++; if (pwm !== 1'b0) begin errors++; $display("FAIL rst_mid_pwm: got %b want 0", pwm); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    checks++; if (period_cnt !== 8'd0) begin errors++; $display("FAIL rst_mid_cnt: got %0d want 0", period_cnt); end
    checks++; if (load_if.load_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", load_if.load_ready); end
    rst_n = 1'b1;
    advance_to(8'd0);
    exp_q.push_back(exp_high(0));
    measure_period(-1, 8'd0, high, ticks, first_hi, ready_lo, high_n, both);
    e = exp_q.pop_front();
    checks++; if (high != e) begin errors++; $display("FAIL rst_duty_cleared: got %0d want %0d", high, e); end
    checks++; if (ready_lo != 0) begin errors++; $display("FAIL rst_pending_dropped: got %0d want 0", ready_lo); end
  endtask

`ifdef PWM_COMPLEMENT_EN
  task automatic test_complement();
    int high, ticks, first_hi, ready_lo, high_n, both;
    measure_period(10, 8'd64, high, ticks, first_hi, ready_lo, high_n, both);
    measure_period(10, 8'd1, high, ticks, first_hi, ready_lo, high_n, both);
    checks++; if (high != 62) begin errors++; $display("FAIL comp_64_pwm: got %0d want 62", high); end
    checks++; if (high_n != 190) begin errors++; $display("FAIL comp_64_pwm_n: got %0d want 190", high_n); end
    checks++; if (both != 0) begin errors++; $display("FAIL comp_64_overlap: got %0d want 0", both); end
    measure_period(-1, 8'd0, high, ticks, first_hi, ready_lo, high_n, both);
    checks++; if (high != 0) begin errors++; $display("FAIL comp_1_pwm: got %0d want 0", high); end
    checks++; if (high_n != 253) begin errors++; $display("FAIL comp_1_pwm_n: got %0d want 253", high_n); end
    checks++; if (both != 0) begin errors++; $display("FAIL comp_1_overlap: got %0d want 0", both); end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_mid_load();
    test_back_to_back_wrap_load();
    test_extremes_and_wrap();
    test_disable_and_reset();
`ifdef PWM_COMPLEMENT_EN
    test_complement();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
